// File: rtl/norm_shift_correct_p24.sv
// norm_shift_correct_p24
// Normalizes a 50-bit magnitude using an externally estimated normalization
// distance that may be one position short, applying a 1-bit correction shift.
// Emits a 24-bit normalized significand, a sticky bit and the true distance.
// Two-stage valid/ready pipeline; at most two beats held.
//
// Ports
//   clock      in   1   single clock, all state on rising edge
//   reset      in   1   synchronous, active-high
//   in_valid   in   1   input beat offered
//   in_ready   out  1   input beat accepted when in_valid & in_ready
//   mag        in   50  magnitude to normalize
//   dist_est   in   7   estimated distance (DIST_OFFSET-biased), legal 24..73
//   out_valid  out  1   result beat offered
//   out_ready  in   1   result consumed when out_valid & out_ready
//   sig        out  24  normalized significand, sig[23]=1 unless out_zero
//   sticky     out  1   OR of the 26 normalized bits below sig
//   norm_dist  out  6   distance actually applied (e + correction); 50 if mag==0
//   out_zero   out  1   mag was zero
//   est_err    out  1   dist_est outside the contract for this mag

module norm_shift_correct_p24 #(
  parameter int unsigned DIST_OFFSET = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [49:0] mag,
  input  logic [6:0]  dist_est,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] sig,
  output logic        sticky,
  output logic [5:0]  norm_dist,
  output logic        out_zero,
  output logic        est_err
);

  localparam logic [6:0] DistMin = 7'(DIST_OFFSET);
  localparam logic [6:0] DistMax = 7'(DIST_OFFSET + 49);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s2_adv;
  logic s1_adv;

  // Decided purely from registered state and out_ready, so in_ready never
  // depends on in_valid.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s2_adv || !s1_valid;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // ---------------------------------------------------------------------------
  // Stage 1: decode and clamp the estimate
  // ---------------------------------------------------------------------------
  logic [5:0]  e_in;
  logic        err1_in;

  always_comb begin
    e_in    = 6'd0;
    err1_in = 1'b0;
    if (dist_est < DistMin) begin
      e_in    = 6'd0;
      err1_in = 1'b1;
    end else if (dist_est > DistMax) begin
      e_in    = 6'd49;
      err1_in = 1'b1;
    end else begin
      e_in = 6'(dist_est - DistMin);
    end
  end

  logic [49:0] s1_mag;
  logic [5:0]  s1_e;
  logic        s1_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
      s1_e     <= '0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mag <= mag;
        s1_e   <= e_in;
        s1_err <= err1_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift by the estimate, then correct by at most one position
  // ---------------------------------------------------------------------------
  logic [99:0] wide;
  logic [49:0] t_est;
  logic        lost;
  logic [49:0] t_fin;
  logic        corr;
  logic        err2;
  logic        mag_zero;

  // Shifting in a 100-bit field keeps the bits pushed past bit 49 visible:
  // any of them set means the estimate overshot the true leading-zero count.
  assign wide     = {50'b0, s1_mag} << s1_e;
  assign t_est    = wide[49:0];
  assign lost     = |wide[99:50];
  assign mag_zero = (s1_mag == '0);

  always_comb begin
    t_fin = t_est;
    corr  = 1'b0;
    err2  = lost;
    if (t_est[49]) begin
      corr = 1'b0;
    end else if (t_est[48]) begin
      corr  = 1'b1;
      t_fin = {t_est[48:0], 1'b0};
    end else begin
      // Estimate is more than one short (or overshot): pass through unshifted.
      err2 = 1'b1;
    end
  end

  logic [23:0] sig_c;
  logic        sticky_c;
  logic [5:0]  dist_c;
  logic        err_c;

  always_comb begin
    if (mag_zero) begin
      sig_c    = '0;
      sticky_c = 1'b0;
      dist_c   = 6'd50;
      err_c    = 1'b0;
    end else begin
      sig_c    = t_fin[49:26];
      sticky_c = |t_fin[25:0];
      dist_c   = s1_e + {5'b0, corr};
      err_c    = s1_err || err2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      sig       <= '0;
      sticky    <= 1'b0;
      norm_dist <= '0;
      out_zero  <= 1'b0;
      est_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      // Result registers only load with a real beat, so they hold otherwise.
      if (s1_valid) begin
        sig       <= sig_c;
        sticky    <= sticky_c;
        norm_dist <= dist_c;
        out_zero  <= mag_zero;
        est_err   <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_norm_shift_correct_p24.sv
module tb_norm_shift_correct_p24;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] mag;
  logic [6:0]  dist_est;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] sig;
  logic        sticky;
  logic [5:0]  norm_dist;
  logic        out_zero;
  logic        est_err;

  norm_shift_correct_p24 #(.DIST_OFFSET(24)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mag       (mag),
    .dist_est  (dist_est),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sig       (sig),
    .sticky    (sticky),
    .norm_dist (norm_dist),
    .out_zero  (out_zero),
    .est_err   (est_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] sig;
    logic        sticky;
    logic [5:0]  nd;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   out_count = 0;
  int   last_wait = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [23:0] s, input logic st, input logic [5:0] nd,
                              input logic z, input logic er);
    exp_t r;
    r.sig = s; r.sticky = st; r.nd = nd; r.zero = z; r.err = er;
    return r;
  endfunction

  // Reference for in-contract beats: find the leading one directly.
  function automatic exp_t model_legal(input logic [49:0] m);
    exp_t        r;
    int          lz;
    logic [49:0] n;
    lz = 0;
    while (lz < 49 && !m[49 - lz]) lz++;
    n = m << lz;
    r.sig = n[49:26]; r.sticky = |n[25:0]; r.nd = 6'(lz); r.zero = 1'b0; r.err = 1'b0;
    return r;
  endfunction

  // Scoreboard consumer.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      chk("unexpected_beat", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sig", 64'(sig), 64'(e.sig));
        chk("sticky", 64'(sticky), 64'(e.sticky));
        chk("norm_dist", 64'(norm_dist), 64'(e.nd));
        chk("out_zero", 64'(out_zero), 64'(e.zero));
        chk("est_err", 64'(est_err), 64'(e.err));
        out_count++;
      end
    end
  end

  // Offer one beat; returns at posedge+1 after the accepting edge.
  task automatic offer(input logic [49:0] m, input logic [6:0] d, input exp_t e,
                       input bit rnd_ready);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; mag = m; dist_est = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (in_ready) begin
        sb.push_back(e);
        last_wait = i;
        ok = 1'b1;
      end
      @(posedge clock); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sb.size() == 0) break;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));
    @(posedge clock); #1;
  endtask

  initial begin
    int cnt0;
    reset = 1'b1; in_valid = 1'b0; mag = '0; dist_est = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_sig", 64'(sig), 64'(0));
    chk("rst_flags", 64'({sticky, out_zero, est_err}), 64'(0));
    chk("rst_norm_dist", 64'(norm_dist), 64'(0));
    @(posedge clock); #1;

    // Latency: beat offered in cycle c appears in cycle c+2.
    offer(50'h1 << 49, 7'd24, mk(24'h800000, 1'b0, 6'd0, 1'b0, 1'b0), 1'b0);
    @(negedge clock);
    chk("lat_c1_out_valid", 64'(out_valid), 64'(0));
    @(negedge clock);
    chk("lat_c2_out_valid", 64'(out_valid), 64'(1));
    @(posedge clock); #1;
    drain();

    // Directed cases.
    offer((50'h1 << 40) | 50'h1, 7'd32, mk(24'h800000, 1'b1, 6'd9, 1'b0, 1'b0), 1'b0);
    offer(50'h1, 7'd73, mk(24'h800000, 1'b0, 6'd49, 1'b0, 1'b0), 1'b0);
    offer(50'h0, 7'd40, mk(24'h0, 1'b0, 6'd50, 1'b1, 1'b0), 1'b0);
    offer(50'h0, 7'd10, mk(24'h0, 1'b0, 6'd50, 1'b1, 1'b0), 1'b0);
    offer(50'h1 << 49, 7'd20, mk(24'h800000, 1'b0, 6'd0, 1'b0, 1'b1), 1'b0);
    offer(50'h1 << 49, 7'd30, mk(24'h0, 1'b0, 6'd6, 1'b0, 1'b1), 1'b0);
    offer(50'h1, 7'd127, mk(24'h800000, 1'b0, 6'd49, 1'b0, 1'b1), 1'b0);
    // Two short: t[49:48]==0, passed unshifted after e.
    offer(50'h1 << 40, 7'd31, mk(24'h200000, 1'b0, 6'd7, 1'b0, 1'b1), 1'b0);
    chk("throughput_wait", 64'(last_wait), 64'(0));
    drain();

    // Stall: two beats fit, the third waits.
    out_ready = 1'b0;
    cnt0 = out_count;
    offer(50'h3 << 45, 7'd27, model_legal(50'h3 << 45), 1'b0);
    offer(50'h5 << 30, 7'd41, model_legal(50'h5 << 30), 1'b0);
    in_valid = 1'b1; mag = 50'h7 << 10; dist_est = 7'd61;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    offer(50'h7 << 10, 7'd61, model_legal(50'h7 << 10), 1'b0);
    drain();
    chk("stall_count", 64'(out_count - cnt0), 64'(3));

    // Reset with two beats in flight.
    out_ready = 1'b0;
    offer(50'h1 << 20, 7'd53, model_legal(50'h1 << 20), 1'b0);
    offer(50'h1 << 21, 7'd52, model_legal(50'h1 << 21), 1'b0);
    reset = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    cnt0 = out_count;
    @(negedge clock);
    chk("rst_flush_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("rst_flush_idle", 64'(out_valid), 64'(0));
    end
    @(posedge clock); #1;
    offer(50'h9 << 12, 7'd58, model_legal(50'h9 << 12), 1'b0);
    drain();
    chk("post_rst_count", 64'(out_count - cnt0), 64'(1));

    // Random in-contract beats with random backpressure.
    for (int k = 0; k < 40; k++) begin
      int           lz;
      int           sh;
      logic [63:0]  rr;
      logic [49:0]  top;
      logic [49:0]  m;
      lz  = $urandom_range(0, 49);
      sh  = (lz > 0) ? $urandom_range(0, 1) : 0;
      rr  = {$urandom(), $urandom()};
      top = 50'h1 << (49 - lz);
      m   = top | (rr[49:0] & (top - 50'h1));
      offer(m, 7'(24 + lz - sh), model_legal(m), 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
